// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal_instr;

    modport master (
        input  op, funct3, funct7, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, imm_src, reg_write, alu_op, illegal_instr
    );

    modport slave (
        output op, funct3, funct7, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, imm_src, reg_write, alu_op, illegal_instr
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core (Moore decode off the state register).
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP until reset.
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus,
    output logic [STATE_W-1:0]     state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    state_t state_q, state_d, cur;
    logic   pc_update, branch;
    logic   ir_write_d, reg_write_d, mem_write_d;

    // funct fields are consumed by the ALU decoder, not by this FSM.
    logic unused_funct;
    assign unused_funct = ^{bus.funct3, bus.funct7};

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // While rst is high the outputs already show FETCH, even if the register
    // still holds a stalled state until the edge.
    assign cur   = rst ? S_FETCH : state_q;
    assign state = STATE_W'(cur);

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update      = 1'b0;
        branch         = 1'b0;
        ir_write_d     = 1'b0;
        reg_write_d    = 1'b0;
        mem_write_d    = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = ALU_ADD;
        case (cur)
            S_FETCH: begin
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                ir_write_d     = bus.mem_ready;
                pc_update      = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            S_MEMREAD:  bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = 2'b01;
                reg_write_d    = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_write_d = 1'b1;
            end
            S_EXECUTER: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = ALU_FN;
            end
            S_ALUWB:    reg_write_d = 1'b1;
            S_EXECUTEI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = ALU_FN;
            end
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                pc_update     = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = ALU_SUB;
                branch        = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.imm_src = 2'b00;
        case (bus.op)
            OP_SW:   bus.imm_src = 2'b01;
            OP_BEQ:  bus.imm_src = 2'b10;
            OP_JAL:  bus.imm_src = 2'b11;
            default: bus.imm_src = 2'b00;
        endcase
    end

    assign bus.pc_write  = ~rst & (pc_update | (branch & bus.zero));
    assign bus.ir_write  = ~rst & ir_write_d;
    assign bus.reg_write = ~rst & reg_write_d;
    assign bus.mem_write = ~rst & mem_write_d;

`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_instr = ~rst & (cur == S_TRAP);
`else
    assign bus.illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] imm;
        logic       regw;
        logic [1:0] aluop;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] state;
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    exp_t       sb[$];

    multicycle_controller_if bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    // Expected output row for a state, from the controller's output table.
    function automatic exp_t e(int s);
        exp_t x;
        x    = '0;
        x.st = s[3:0];
        case (bus.op)
            SW:      x.imm = 2'b01;
            BQ:      x.imm = 2'b10;
            JL:      x.imm = 2'b11;
            default: x.imm = 2'b00;
        endcase
        case (s)
            0:  begin x.res = 2; x.b = 2; x.irw = bus.mem_ready; x.pcw = bus.mem_ready; end
            1:  begin x.a = 1; x.b = 1; end
            2:  begin x.a = 2; x.b = 1; end
            3:  x.adr = 1;
            4:  begin x.res = 1; x.regw = 1; end
            5:  begin x.adr = 1; x.memw = 1; end
            6:  begin x.a = 2; x.aluop = 2; end
            7:  x.regw = 1;
            8:  begin x.a = 2; x.b = 1; x.aluop = 2; end
            9:  begin x.a = 1; x.b = 2; x.pcw = 1; end
            10: begin x.a = 2; x.aluop = 1; x.pcw = bus.zero; end
            11: x.ill = 1;
            default: ;
        endcase
        return x;
    endfunction

    // Reset row: FETCH selects, every enable low.
    function automatic exp_t er();
        exp_t x;
        x     = e(0);
        x.irw = 1'b0;
        x.pcw = 1'b0;
        return x;
    endfunction

    task automatic step(input exp_t x);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [6:0] o, input logic rdy, input logic z, input int s);
        bus.op        = o;
        bus.mem_ready = rdy;
        bus.zero      = z;
        step(e(s));
    endtask

    always @(negedge clk) begin
        exp_t got, want;
        cyc++;
        if (sb.size() != 0) begin
            want = sb.pop_front();
            got  = '{st: state, pcw: bus.pc_write, adr: bus.adr_src,
                     memw: bus.mem_write, irw: bus.ir_write, res: bus.result_src,
                     a: bus.alu_src_a, b: bus.alu_src_b, imm: bus.imm_src,
                     regw: bus.reg_write, aluop: bus.alu_op, ill: bus.illegal_instr};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cyc%0d st%0d: got=%h exp=%h", cyc, want.st, got, want);
            end
        end
    end

    initial begin
        bus.op        = SW;
        bus.funct3    = 3'b000;
        bus.funct7    = 7'b0000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(er());
        // Drive into a stalled MEMWRITE, then reset over it.
        rst = 1'b0;
        run(SW, 1, 0, 0);
        run(SW, 1, 0, 1);
        run(SW, 1, 0, 2);
        run(SW, 0, 0, 5);
        run(SW, 0, 0, 5);
        rst = 1'b1;
        step(er());
        step(er());
        rst = 1'b0;
        run(SW, 0, 0, 0);
        // lw, zero high to show it does not leak into pc_write
        run(LW, 1, 1, 0);
        run(LW, 1, 1, 1);
        run(LW, 1, 1, 2);
        run(LW, 1, 1, 3);
        run(LW, 1, 1, 4);
        // sw with three stall cycles in MEMWRITE
        run(SW, 1, 0, 0);
        run(SW, 0, 0, 1);
        run(SW, 0, 0, 2);
        run(SW, 0, 0, 5);
        run(SW, 0, 0, 5);
        run(SW, 0, 0, 5);
        run(SW, 1, 0, 5);
        // beq taken, then not taken
        run(BQ, 1, 1, 0);
        run(BQ, 1, 1, 1);
        run(BQ, 1, 1, 10);
        run(BQ, 1, 0, 0);
        run(BQ, 1, 0, 1);
        run(BQ, 1, 0, 10);
        // R-type, jal, I-ALU
        run(RT, 1, 0, 0);
        run(RT, 1, 0, 1);
        run(RT, 1, 0, 6);
        run(RT, 1, 0, 7);
        run(JL, 1, 0, 0);
        run(JL, 1, 0, 1);
        run(JL, 1, 0, 9);
        run(JL, 1, 0, 7);
        run(IA, 1, 0, 0);
        run(IA, 1, 0, 1);
        run(IA, 1, 0, 8);
        run(IA, 1, 0, 7);
        // illegal opcode
        run(BAD, 1, 0, 0);
        run(BAD, 1, 0, 1);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) run(BAD, i[0], i[1], 11);
        rst = 1'b1;
        step(er());
        rst = 1'b0;
        run(BAD, 0, 0, 0);
`else
        run(BAD, 0, 0, 0);
        run(BAD, 0, 0, 0);
`endif
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d pending exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the single shared ALU, the unified instruction/data memory port, the instruction register, the PC and the register file across fetch, decode, execute, memory and writeback steps.
- Emits ALUOp to the existing ALU decoder: 00 = add, 01 = subtract, 10 = decode from funct3/funct7.
- Memory-port accesses stall on a ready handshake.

Parameters:
- STATE_W, 4, width of debug state output; must be >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  7  instruction[6:0], from the IR.
- funct3  input  3  instruction[14:12], from the IR.
- funct7  input  7  instruction[31:25], from the IR.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR and OldPC enable.
- result_src  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RegA.
- alu_src_b  output  2  ALU B select: 00 = RegB, 01 = ImmExt, 10 = constant 4.
- imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  output  1  register file write enable.
- alu_op  output  2  to the ALU decoder.
- illegal_instr  output  1  illegal opcode flag.
- state  output  STATE_W  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- State register:
  - rst high at a clk edge -> state = FETCH (0).
  - Reset overrides any in-progress state, including a stalled MEMWRITE.
- Output timing:
  - Outputs are combinational from the state register (Moore), except pc_write (uses zero) and the enables gated by mem_ready.
  - imm_src is decoded from op only: lw / I-ALU -> 00, sw -> 01, beq -> 10, jal -> 11, others -> 00.
- During reset: pc_write, ir_write, reg_write, mem_write and illegal_instr are forced 0. Mux selects take their FETCH values. state reads 0.
- Defaults: every output not listed for a state is 0.
- pc_write = pc_update | (branch & zero), where pc_update and branch are internal.
- State encodings, outputs and transitions:
  - FETCH (0): adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write = pc_update = mem_ready. Go to DECODE when mem_ready, else hold.
  - DECODE (1): alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> illegal-opcode handling (see Optional Feature).
  - MEMADR (2): alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD (3): adr_src=1, result_src=00. Go to MEMWB when mem_ready, else hold.
  - MEMWB (4): result_src=01, reg_write=1. Go to FETCH.
  - MEMWRITE (5): adr_src=1, result_src=00, mem_write=1. mem_write stays asserted every cycle until mem_ready, then go to FETCH.
  - EXECUTER (6): alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
  - ALUWB (7): result_src=00, reg_write=1. Go to FETCH.
  - EXECUTEI (8): alu_src_a=10, alu_src_b=01, alu_op=10. Go to ALUWB.
  - JAL (9): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Go to ALUWB.
  - BEQ (10): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Go to FETCH.
- Latency with mem_ready tied 1: lw 5 cycles; sw 4; R-type and I-ALU 4; jal 4; beq 3.
- mem_ready is ignored in states other than FETCH, MEMREAD and MEMWRITE.
- Unused encodings 12-15 -> FETCH on the next edge, all enables 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Illegal op in DECODE -> TRAP (11).
  - TRAP: illegal_instr=1, all enables 0; held until rst.
- Not defined:
  - Illegal op in DECODE -> FETCH. The instruction acts as a NOP; PC was already advanced in FETCH.
  - illegal_instr tied 0; encoding 11 is unused.

Test Plan:
- Reset: rst high 2 cycles during MEMWRITE with mem_ready=0 -> state=0, mem_write=0 while rst high; FETCH outputs on release.
- lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4,0. reg_write=1 and result_src=01 only in cycle 5. ir_write=1 only in cycle 1.
- sw with mem_ready=0 for 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, then FETCH; reg_write never 1.
- beq with zero=1 -> pc_write=1 in BEQ, alu_op=01. With zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- R-type (op=0110011) then jal (op=1101111) -> alu_op=10 in EXECUTER. JAL state has pc_write=1, alu_src_a=01, alu_src_b=10. ALUWB follows each.
- op=1111111, both builds: with ILLEGAL_TRAP_EN -> state=11, illegal_instr=1 held for 10 cycles. Without -> state=0 next cycle, illegal_instr=0.
